w_normalise: RTL and testbench
==============================

W_NORMALISE -- requirements
Module: w_normalise

Interface
REQ-001 Parameter SIZE_N, default 8: number of elements in the weight vector.
REQ-002 Parameter N_BITS_VEC, default 32: signed element width.
REQ-003 Parameter FRAC_BITS, default 16: fractional bits of the fixed-point element format.
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous and active-low.
REQ-006 Port start, input, 1: request normalisation of w_second.
REQ-007 Port w_second, input, signed [N_BITS_VEC-1:0] [SIZE_N][1]: deflated weight vector from the Gram-Schmidt stage.
REQ-008 Port w_norm, output, signed [N_BITS_VEC-1:0] [SIZE_N][1]: unit-norm weight vector.
REQ-009 Port busy, output, 1: high while a normalisation is in progress.
REQ-010 Port valid, output, 1: one-cycle pulse when w_norm is updated.
REQ-011 Port zero_err, output, 1: high when the last result came from a zero-norm input.

Function
REQ-012 The FSM SHALL have states IDLE, ACCUM, SQRT, RECIP, SCALE and DONE.
REQ-013 In IDLE, start=1 SHALL latch w_second and move to ACCUM on the same edge; start is ignored in every other state.
REQ-014 ACCUM SHALL add one squared element per cycle (index 0 first) to an unsigned accumulator of ACC_W = 2*N_BITS_VEC + clog2(SIZE_N) bits, for exactly SIZE_N cycles.
REQ-015 SQRT SHALL compute norm = floor(sqrt(acc)) with a restoring bit-serial method, one result bit per cycle, for exactly ceil(ACC_W/2) cycles.
REQ-016 norm SHALL be in Q(FRAC_BITS) format.
REQ-017 If norm = 0, the FSM SHALL go from SQRT directly to DONE, load every w_norm element with 0 and set zero_err=1.
REQ-018 Otherwise RECIP SHALL compute recip = floor(2^(2*FRAC_BITS) / norm) in exactly N_BITS_VEC cycles.
REQ-019 recip SHALL saturate to 2^(N_BITS_VEC-1)-1 if the true quotient exceeds that value.
REQ-020 SCALE SHALL process one element per cycle for SIZE_N cycles: out_i = (w_i * recip) >>> FRAC_BITS.
REQ-021 The product in SCALE SHALL be a full 2*N_BITS_VEC-bit signed product; the shift is arithmetic (truncation toward minus infinity).
REQ-022 out_i SHALL saturate to the signed N_BITS_VEC range.
REQ-023 Scaled results SHALL go to an internal buffer; w_norm SHALL change only on the edge where valid rises, and SHALL hold between completions.
REQ-024 DONE SHALL last one cycle with valid=1, then return to IDLE; a start in that same cycle is ignored.
REQ-025 busy SHALL be 1 in ACCUM, SQRT, RECIP and SCALE, and 0 in IDLE and DONE.
REQ-026 zero_err SHALL update only when valid rises: 1 for a zero-norm result, 0 otherwise.
REQ-027 Latency: with start sampled at edge k, valid SHALL rise at edge k+1+2*SIZE_N+ceil(ACC_W/2)+N_BITS_VEC.
REQ-028 With the default parameters that edge is k+83.
REQ-029 Zero-norm latency SHALL be k+1+SIZE_N+ceil(ACC_W/2), which is k+43 with the default parameters.

Reset
REQ-030 While rst=0, the FSM SHALL be IDLE and w_norm, busy, valid, zero_err, the accumulator and the internal buffer SHALL all be 0.
REQ-031 Reset asserted mid-operation SHALL abort the operation without producing valid.
REQ-032 After reset deasserts, the first start SHALL be handled normally.

Verification (defaults: SIZE_N=8, N_BITS_VEC=32, FRAC_BITS=16)
REQ-033 Input w=[196608, 262144, 0 x6] (3.0, 4.0) with start -> valid at k+83; w_norm=[39321, 52428, 0 x6]; zero_err=0; busy high from edge k+1 until edge k+83.
REQ-034 Input all elements 65536 -> norm=185363, recip=23170; every w_norm element = 23170.
REQ-035 Input w=[-65536, 0 x7] -> w_norm=[-65536, 0 x7].
REQ-036 All-zero input -> valid at k+43; zero_err=1; w_norm all 0.
REQ-037 Assert start while busy -> no effect: a single valid at k+83 with the first vector's result.
REQ-038 Assert rst at cycle k+40 of an operation -> all outputs 0 and no valid; a new start after release gives the correct result at the normal latency.

Source files
------------

// File: rtl/w_normalise.sv
// w_normalise: scales a weight vector to unit Euclidean norm in Q(FRAC_BITS) fixed point
// (sum of squares -> bit-serial sqrt -> bit-serial reciprocal -> per-element scale).
module w_normalise #(
    parameter int SIZE_N     = 8,
    parameter int N_BITS_VEC = 32,
    parameter int FRAC_BITS  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic signed [N_BITS_VEC-1:0] w_second [SIZE_N][1],
    output logic signed [N_BITS_VEC-1:0] w_norm   [SIZE_N][1],
    output logic                         busy,
    output logic                         valid,
    output logic                         zero_err
);
    typedef enum logic [2:0] {IDLE, ACCUM, SQRT, RECIP, SCALE, DONE} state_t;
    localparam int ACC_W = 2*N_BITS_VEC + $clog2(SIZE_N);
    localparam int SQ_N  = (ACC_W + 1) / 2;
    localparam int ACC_P = 2*SQ_N;
    localparam int RW    = SQ_N + 2;
    localparam int IW    = SIZE_N > 1 ? $clog2(SIZE_N) : 1;
    localparam int CW    = $clog2(SQ_N + N_BITS_VEC + SIZE_N + 1);
    localparam int SW    = SQ_N + N_BITS_VEC + 2*FRAC_BITS;
    localparam int R0_SH = 2*FRAC_BITS >= N_BITS_VEC ? 2*FRAC_BITS - N_BITS_VEC : 0;
    // dividend bits above the N_BITS_VEC iterated ones are preloaded into the remainder
    localparam logic [RW-1:0] DIV_R0 = 2*FRAC_BITS >= N_BITS_VEC ? RW'(1) << R0_SH : '0;
    localparam logic signed [N_BITS_VEC-1:0] S_MAX = {1'b0, {(N_BITS_VEC-1){1'b1}}};
    localparam logic signed [N_BITS_VEC-1:0] S_MIN = {1'b1, {(N_BITS_VEC-1){1'b0}}};

    state_t                        state_q, state_d;
    logic [CW-1:0]                 cnt_q, cnt_d;
    logic [ACC_P-1:0]              acc_q, acc_d;
    logic [RW-1:0]                 rem_q, rem_d;
    logic [SQ_N-1:0]               root_q, root_d;
    logic signed [N_BITS_VEC-1:0]  quo_q, quo_d;
    logic                          busy_q, valid_q, zero_err_q;
    logic signed [N_BITS_VEC-1:0]  w_q      [SIZE_N][1];
    logic signed [N_BITS_VEC-1:0]  sbuf_q   [SIZE_N][1];
    logic signed [N_BITS_VEC-1:0]  w_norm_q [SIZE_N][1];

    logic [IW-1:0]                 idx;
    logic signed [N_BITS_VEC-1:0]  cur_w, scaled;
    logic signed [2*N_BITS_VEC-1:0] sq, prod, sh;
    logic [N_BITS_VEC:0]           hi;
    logic [RW-1:0]                 sq_sh, trial, dv_sh;
    logic                          sq_ge, dv_ge, dbit, sat, last;
    int                            lim;

    assign idx    = cnt_q[IW-1:0];
    assign cur_w  = w_q[idx][0];
    assign sq     = (2*N_BITS_VEC)'(cur_w) * (2*N_BITS_VEC)'(cur_w);
    assign sq_sh  = RW'({rem_q, acc_q[ACC_P-1 -: 2]});
    assign trial  = {root_q, 2'b01};
    assign sq_ge  = sq_sh >= trial;
    assign dbit   = int'(cnt_q) == N_BITS_VEC - 1 - 2*FRAC_BITS;
    assign dv_sh  = RW'({rem_q, dbit});
    assign dv_ge  = dv_sh >= RW'(root_q);
    // quotient reaches 2^(N_BITS_VEC-1) exactly when norm * 2^(N_BITS_VEC-1) <= 2^(2*FRAC_BITS)
    assign sat    = (SW'(root_q) << (N_BITS_VEC-1)) <= (SW'(1) << (2*FRAC_BITS));
    assign prod   = (2*N_BITS_VEC)'(cur_w) * (2*N_BITS_VEC)'(quo_q);
    assign sh     = prod >>> FRAC_BITS;
    assign hi     = sh[2*N_BITS_VEC-1:N_BITS_VEC-1];
    assign scaled = (&hi || ~|hi) ? sh[N_BITS_VEC-1:0] : (sh[2*N_BITS_VEC-1] ? S_MIN : S_MAX);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        acc_d   = acc_q;
        rem_d   = rem_q;
        root_d  = root_q;
        quo_d   = quo_q;
        lim     = state_q == SQRT ? SQ_N : state_q == RECIP ? N_BITS_VEC : SIZE_N;
        last    = int'(cnt_q) == lim - 1;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    rem_d   = '0;
                    root_d  = '0;
                end
            end
            ACCUM: begin
                acc_d = acc_q + ACC_P'($unsigned(sq));
                if (last) begin
                    state_d = SQRT;
                    cnt_d   = '0;
                end
            end
            SQRT: begin
                acc_d  = acc_q << 2;
                rem_d  = sq_ge ? sq_sh - trial : sq_sh;
                root_d = {root_q[SQ_N-2:0], sq_ge};
                if (last) begin
                    state_d = root_d == '0 ? DONE : RECIP;
                    rem_d   = DIV_R0;
                    cnt_d   = '0;
                end
            end
            RECIP: begin
                rem_d = dv_ge ? dv_sh - RW'(root_q) : dv_sh;
                quo_d = (last && sat) ? S_MAX : {quo_q[N_BITS_VEC-2:0], dv_ge};
                if (last) begin
                    state_d = SCALE;
                    cnt_d   = '0;
                end
            end
            SCALE: state_d = last ? DONE : SCALE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            rem_q      <= '0;
            root_q     <= '0;
            quo_q      <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            zero_err_q <= 1'b0;
            for (int i = 0; i < SIZE_N; i++) begin
                w_q[i][0]      <= '0;
                sbuf_q[i][0]   <= '0;
                w_norm_q[i][0] <= '0;
            end
        end else begin
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            root_q  <= root_d;
            quo_q   <= quo_d;
            busy_q  <= state_q inside {ACCUM, SQRT, RECIP, SCALE};
            valid_q <= state_q == DONE;
            if (state_q == DONE) begin
                zero_err_q <= root_q == '0;
                w_norm_q   <= sbuf_q;
            end
            // clearing the buffer on start makes a zero-norm result publish all zeros
            if (state_q == IDLE && start) begin
                w_q <= w_second;
                for (int i = 0; i < SIZE_N; i++) sbuf_q[i][0] <= '0;
            end
            if (state_q == SCALE) sbuf_q[idx][0] <= scaled;
        end
    end

    assign w_norm   = w_norm_q;
    assign busy     = busy_q;
    assign valid    = valid_q;
    assign zero_err = zero_err_q;
endmodule

// File: tb/tb_w_normalise.sv
// tb_w_normalise: directed vectors for w_normalise; expected results queued at issue
// and compared by a monitor whenever valid is seen.
module tb_w_normalise;
    localparam int N = 8;
    typedef logic [N-1:0][31:0] vec_t;
    typedef struct packed {
        vec_t        v;
        logic        z;
        logic [31:0] due;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst, start;
    logic signed [31:0] w_second [N][1];
    logic signed [31:0] w_norm   [N][1];
    logic               busy, valid, zero_err;
    int                 cyc = 0;
    int                 total = 0;
    int                 bad = 0;
    exp_t               q[$];
    exp_t               mon_e;

    w_normalise #(.SIZE_N(8), .N_BITS_VEC(32), .FRAC_BITS(16)) dut (
        .clk(clk), .rst(rst), .start(start), .w_second(w_second),
        .w_norm(w_norm), .busy(busy), .valid(valid), .zero_err(zero_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input longint got, input longint exp_v);
        total++;
        if (got !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp_v, cyc);
        end
    endtask

    task automatic load(input vec_t v);
        for (int i = 0; i < N; i++) w_second[i][0] = v[i];
    endtask

    task automatic issue(input vec_t v, input vec_t e, input logic z, input int lat, input bit expect_it);
        @(negedge clk);
        load(v);
        start = 1'b1;
        if (expect_it) q.push_back('{v: e, z: z, due: 32'(cyc + 1 + lat)});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, " busy"}, busy, 0);
        check({tag, " valid"}, valid, 0);
        check({tag, " zero_err"}, zero_err, 0);
        for (int i = 0; i < N; i++) check($sformatf("%s w_norm[%0d]", tag, i), w_norm[i][0], 0);
    endtask

    always @(negedge clk) begin
        if (valid) begin
            if (q.size() == 0) check("spurious valid cycle", longint'(cyc), -1);
            else begin
                mon_e = q.pop_front();
                check("latency", longint'(cyc), longint'(mon_e.due));
                check("zero_err", zero_err, mon_e.z);
                for (int i = 0; i < N; i++)
                    check($sformatf("w_norm[%0d]", i), w_norm[i][0], $signed(mon_e.v[i]));
            end
        end else if (q.size() > 0 && cyc > int'(q[0].due)) begin
            check("valid timeout", longint'(cyc), longint'(q[0].due));
            void'(q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t va, ea, vb, eb, vc, vs, es, ve, ee, zv;
        zv = '0;
        va = '0; va[0] = 196608; va[1] = 262144;
        ea = '0; ea[0] = 39321;  ea[1] = 52428;
        for (int i = 0; i < N; i++) begin
            vb[i] = 65536;
            eb[i] = 23170;
        end
        vc = '0; vc[0] = -65536;
        vs = '0; vs[0] = 1;     vs[1] = -1;
        es = '0; es[0] = 32767; es[1] = -32768;
        ve = '0; ve[3] = 262144;
        ee = '0; ee[3] = 65536;

        rst = 1'b1;
        start = 1'b0;
        load(zv);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check_zero_outputs("reset");
        @(negedge clk);
        rst = 1'b1;

        issue(va, ea, 1'b0, 83, 1'b1);
        check("busy edge k", busy, 0);
        @(negedge clk);
        check("busy edge k+1", busy, 1);
        repeat (81) @(negedge clk);
        check("busy edge k+82", busy, 1);
        @(negedge clk);
        check("busy edge k+83", busy, 0);
        repeat (3) @(negedge clk);

        issue(vb, eb, 1'b0, 83, 1'b1);
        repeat (86) @(negedge clk);
        issue(vc, vc, 1'b0, 83, 1'b1);
        repeat (86) @(negedge clk);
        issue(zv, zv, 1'b1, 43, 1'b1);
        repeat (46) @(negedge clk);
        issue(vs, es, 1'b0, 83, 1'b1);
        repeat (86) @(negedge clk);

        issue(ve, ee, 1'b0, 83, 1'b1);
        repeat (10) @(negedge clk);
        load(va);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (71) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (90) @(negedge clk);

        issue(va, zv, 1'b0, 83, 1'b0);
        repeat (39) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_zero_outputs("abort");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (90) @(negedge clk);

        issue(vb, eb, 1'b0, 83, 1'b1);
        repeat (86) @(negedge clk);
        check("pending results", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
